// File: rtl/div_unit_if.sv
// Handshake and data bundle between the execute stage and the multi-cycle divider.
interface div_if #(
   parameter int WIDTH = 32
);
   logic               start_i;
   logic               signed_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic               annul_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;
   logic               divstall_o;

   modport master (
      output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
      input  result_o, ready_o, divstall_o
   );

   modport slave (
      input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
      output result_o, ready_o, divstall_o
   );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, sign fix-up
// applied as the result is registered, stall request held until the ready cycle.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);
   localparam int             CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIVZERO = 2'd1,
      S_ON      = 2'd2,
      S_END     = 2'd3
   } state_t;

   function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   state_t             r_state, w_state_nxt;
   logic [CW-1:0]      r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0]   r_rem, w_rem_nxt;
   logic [WIDTH-1:0]   r_quo, w_quo_nxt;
   logic [WIDTH-1:0]   r_dsr, w_dsr_nxt;
   logic               r_neg_q, w_neg_q_nxt;
   logic               r_neg_r, w_neg_r_nxt;
   logic [2*WIDTH-1:0] r_result, w_result_nxt;
   logic               r_ready, w_ready_nxt;

   logic               w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag;
   logic [WIDTH:0]     w_shift, w_trial;
   logic [WIDTH-1:0]   w_rem_it, w_quo_it;
   logic [CW-1:0]      w_cnt_inc;

   assign w_a_neg   = bus.signed_i & bus.opdata1_i[WIDTH-1];
   assign w_b_neg   = bus.signed_i & bus.opdata2_i[WIDTH-1];
   assign w_a_mag   = w_a_neg ? f_neg(bus.opdata1_i) : bus.opdata1_i;
   assign w_b_mag   = w_b_neg ? f_neg(bus.opdata2_i) : bus.opdata2_i;

   // The shifted remainder can exceed WIDTH bits, so the trial subtract uses one extra bit.
   assign w_shift   = {r_rem, r_quo[WIDTH-1]};
   assign w_trial   = w_shift - {1'b0, r_dsr};
   assign w_rem_it  = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign w_quo_it  = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
   assign w_cnt_inc = r_cnt + CNT_ONE;

   // Next-state and datapath update; annul overrides everything and leaves result untouched.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_rem_nxt    = r_rem;
      w_quo_nxt    = r_quo;
      w_dsr_nxt    = r_dsr;
      w_neg_q_nxt  = r_neg_q;
      w_neg_r_nxt  = r_neg_r;
      w_result_nxt = r_result;
      w_ready_nxt  = 1'b0;
      if (bus.annul_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start_i) begin
                  w_neg_q_nxt = w_a_neg ^ w_b_neg;
                  w_neg_r_nxt = w_a_neg;
                  w_quo_nxt   = w_a_mag;
                  w_dsr_nxt   = w_b_mag;
                  w_rem_nxt   = {WIDTH{1'b0}};
                  w_cnt_nxt   = {CW{1'b0}};
                  if (bus.opdata2_i == {WIDTH{1'b0}}) begin
                     w_state_nxt = S_DIVZERO;
                  end else begin
                     w_state_nxt = S_ON;
                  end
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_DIVZERO: begin
               w_result_nxt = {(2*WIDTH){1'b0}};
               w_ready_nxt  = 1'b1;
               w_state_nxt  = S_END;
            end
            S_ON: begin
               w_rem_nxt = w_rem_it;
               w_quo_nxt = w_quo_it;
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == CNT_LAST) begin
                  w_result_nxt = {(r_neg_r ? f_neg(w_rem_it) : w_rem_it),
                                  (r_neg_q ? f_neg(w_quo_it) : w_quo_it)};
                  w_ready_nxt  = 1'b1;
                  w_state_nxt  = S_END;
               end else begin
                  w_state_nxt = S_ON;
               end
            end
            S_END: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers; reset discards any divide in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= {CW{1'b0}};
         r_rem    <= {WIDTH{1'b0}};
         r_quo    <= {WIDTH{1'b0}};
         r_dsr    <= {WIDTH{1'b0}};
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= {(2*WIDTH){1'b0}};
         r_ready  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rem    <= w_rem_nxt;
         r_quo    <= w_quo_nxt;
         r_dsr    <= w_dsr_nxt;
         r_neg_q  <= w_neg_q_nxt;
         r_neg_r  <= w_neg_r_nxt;
         r_result <= w_result_nxt;
         r_ready  <= w_ready_nxt;
      end
   end

   assign bus.result_o   = r_result;
   assign bus.ready_o    = r_ready;
   assign bus.divstall_o = bus.start_i & ~r_ready;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected {rem, quo} queued at each start, compared at ready.
module tb_div_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_if #(.WIDTH(32)) dif();
   div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(dif.slave));

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];

   function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ma, mb, q, r;
      bit na, nb;
      if (b == 32'd0) return 64'd0;
      na = sgn && a[31];
      nb = sgn && b[31];
      ma = na ? (32'd0 - a) : a;
      mb = nb ? (32'd0 - b) : b;
      q  = ma / mb;
      r  = ma % mb;
      if (na ^ nb) q = 32'd0 - q;
      if (na) r = 32'd0 - r;
      return {r, q};
   endfunction

   task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit chained, input bit keep_start,
                         output int lat, output int stalls, output bit stall_at_ready,
                         output logic [63:0] res, output bit got);
      if (!chained) @(negedge clk);
      dif.start_i   = 1'b1;
      dif.signed_i  = sgn;
      dif.opdata1_i = a;
      dif.opdata2_i = b;
      exp_q.push_back(model(sgn, a, b));
      #1;
      stalls = int'(dif.divstall_o);
      lat = 0; got = 1'b0; res = 64'd0; stall_at_ready = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (dif.ready_o) begin
            got = 1'b1;
            res = dif.result_o;
            stall_at_ready = dif.divstall_o;
            if (!keep_start) dif.start_i = 1'b0;
         end else begin
            stalls += int'(dif.divstall_o);
            if (i >= 2) begin
               dif.opdata1_i = $urandom;
               dif.opdata2_i = $urandom;
               dif.signed_i  = 1'($urandom);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      dif.start_i = 1'b0; dif.signed_i = 1'b0; dif.annul_i = 1'b0;
      dif.opdata1_i = 32'd0; dif.opdata2_i = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (dif.result_o !== 64'd0) begin n_err++; $display("FAIL reset_result got=%h want=0", dif.result_o); end
      n_vec++; if (dif.ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b want=0", dif.ready_o); end
      n_vec++; if (dif.divstall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b want=0", dif.divstall_o); end
   endtask

   task automatic test_unsigned;
      int lat, st; bit sar, got; logic [63:0] res, e;
      do_div(1'b0, 32'd100, 32'd7, 1'b0, 1'b0, lat, st, sar, res, got);
      e = exp_q.pop_front();
      n_vec++; if (!got) begin n_err++; $display("FAIL udiv_timeout no ready within bound"); end
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL udiv_latency got=%0d want=33", lat); end
      n_vec++; if (st !== 33) begin n_err++; $display("FAIL udiv_stall_cycles got=%0d want=33", st); end
      n_vec++; if (sar !== 1'b0) begin n_err++; $display("FAIL udiv_stall_at_ready got=%b want=0", sar); end
      n_vec++; if (res !== e) begin n_err++; $display("FAIL udiv_result got=%h want=%h", res, e); end
      n_vec++; if (res !== 64'h00000002_0000000E) begin n_err++; $display("FAIL udiv_const got=%h want=000000020000000e", res); end
      @(negedge clk);
      n_vec++; if (dif.ready_o !== 1'b0) begin n_err++; $display("FAIL udiv_ready_one_cycle got=%b want=0", dif.ready_o); end
      n_vec++; if (dif.result_o !== 64'h00000002_0000000E) begin n_err++; $display("FAIL udiv_result_hold got=%h want=000000020000000e", dif.result_o); end
   endtask

   task automatic test_reset_mid;
      int rdy; int lat, st; bit sar, got; logic [63:0] res, e;
      @(negedge clk);
      dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd1000; dif.opdata2_i = 32'd3;
      repeat (11) @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++; if (dif.result_o !== 64'd0) begin n_err++; $display("FAIL rstmid_result got=%h want=0", dif.result_o); end
      n_vec++; if (dif.ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_ready got=%b want=0", dif.ready_o); end
      n_vec++; if (dif.divstall_o !== 1'b1) begin n_err++; $display("FAIL rstmid_stall_start_hi got=%b want=1", dif.divstall_o); end
      dif.start_i = 1'b0;
      #1;
      n_vec++; if (dif.divstall_o !== 1'b0) begin n_err++; $display("FAIL rstmid_stall_start_lo got=%b want=0", dif.divstall_o); end
      @(negedge clk);
      rst = 1'b0;
      rdy = 0;
      repeat (40) begin @(negedge clk); rdy += int'(dif.ready_o); end
      n_vec++; if (rdy !== 0) begin n_err++; $display("FAIL rstmid_spurious_ready got=%0d want=0", rdy); end
      do_div(1'b0, 32'd1000, 32'd3, 1'b0, 1'b0, lat, st, sar, res, got);
      e = exp_q.pop_front();
      n_vec++; if (!got || lat !== 33) begin n_err++; $display("FAIL rstmid_after_latency got=%0d want=33", lat); end
      n_vec++; if (res !== e) begin n_err++; $display("FAIL rstmid_after_result got=%h want=%h", res, e); end
   endtask

   task automatic test_signed;
      logic [31:0] ta[3];
      logic [31:0] tb[3];
      logic [63:0] tr[3];
      int lat, st; bit sar, got; logic [63:0] res, e;
      ta[0] = 32'hFFFFFFF9; tb[0] = 32'd2;        tr[0] = 64'hFFFFFFFF_FFFFFFFD;
      ta[1] = 32'd7;        tb[1] = 32'hFFFFFFFE; tr[1] = 64'h00000001_FFFFFFFD;
      ta[2] = 32'h80000000; tb[2] = 32'hFFFFFFFF; tr[2] = 64'h00000000_80000000;
      for (int k = 0; k < 3; k++) begin
         do_div(1'b1, ta[k], tb[k], 1'b0, 1'b0, lat, st, sar, res, got);
         e = exp_q.pop_front();
         n_vec++; if (!got || lat !== 33) begin n_err++; $display("FAIL sdiv%0d_latency got=%0d want=33", k, lat); end
         n_vec++; if (res !== e) begin n_err++; $display("FAIL sdiv%0d_result got=%h want=%h", k, res, e); end
         n_vec++; if (res !== tr[k]) begin n_err++; $display("FAIL sdiv%0d_const got=%h want=%h", k, res, tr[k]); end
      end
   endtask

   task automatic test_divzero;
      int lat, st; bit sar, got; logic [63:0] res, e;
      do_div(1'b0, 32'd5, 32'd0, 1'b0, 1'b0, lat, st, sar, res, got);
      e = exp_q.pop_front();
      n_vec++; if (!got || lat !== 2) begin n_err++; $display("FAIL dz_latency got=%0d want=2", lat); end
      n_vec++; if (res !== 64'd0) begin n_err++; $display("FAIL dz_result got=%h want=0", res); end
      do_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, lat, st, sar, res, got);
      e = exp_q.pop_front();
      n_vec++; if (!got || lat !== 33) begin n_err++; $display("FAIL dz_next_latency got=%0d want=33", lat); end
      n_vec++; if (res !== e || res !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL dz_next_result got=%h want=00000000ffffffff", res); end
   endtask

   task automatic test_annul;
      int rdy; int lat, st; bit sar, got; logic [63:0] res, e;
      @(negedge clk);
      dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd1000; dif.opdata2_i = 32'd3;
      repeat (15) @(negedge clk);
      dif.annul_i = 1'b1; dif.start_i = 1'b0;
      @(negedge clk);
      dif.annul_i = 1'b0;
      n_vec++; if (dif.ready_o !== 1'b0) begin n_err++; $display("FAIL annul_ready got=%b want=0", dif.ready_o); end
      rdy = 0;
      repeat (40) begin @(negedge clk); rdy += int'(dif.ready_o); end
      n_vec++; if (rdy !== 0) begin n_err++; $display("FAIL annul_no_pulse got=%0d want=0", rdy); end
      n_vec++; if (dif.result_o !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL annul_hold got=%h want=00000000ffffffff", dif.result_o); end
      do_div(1'b0, 32'd1000, 32'd3, 1'b0, 1'b0, lat, st, sar, res, got);
      e = exp_q.pop_front();
      n_vec++; if (!got || lat !== 33) begin n_err++; $display("FAIL annul_after_latency got=%0d want=33", lat); end
      n_vec++; if (res !== e || res !== 64'h00000001_0000014D) begin n_err++; $display("FAIL annul_after_result got=%h want=000000010000014d", res); end
   endtask

   task automatic test_back_to_back;
      int lat1, lat2, st1, st2; bit sar1, sar2, got1, got2; logic [63:0] res1, res2, e;
      do_div(1'b0, 32'd9, 32'd3, 1'b0, 1'b1, lat1, st1, sar1, res1, got1);
      do_div(1'b0, 32'd10, 32'd4, 1'b1, 1'b0, lat2, st2, sar2, res2, got2);
      e = exp_q.pop_front();
      n_vec++; if (!got1 || res1 !== e || res1 !== 64'h00000000_00000003) begin n_err++; $display("FAIL b2b_first got=%h want=0000000000000003", res1); end
      e = exp_q.pop_front();
      n_vec++; if (!got2 || res2 !== e || res2 !== 64'h00000002_00000002) begin n_err++; $display("FAIL b2b_second got=%h want=0000000200000002", res2); end
      n_vec++; if (lat1 !== 33) begin n_err++; $display("FAIL b2b_first_latency got=%0d want=33", lat1); end
      n_vec++; if (lat2 !== 34) begin n_err++; $display("FAIL b2b_pulse_spacing got=%0d want=34", lat2); end
      n_vec++; if (st2 !== 33) begin n_err++; $display("FAIL b2b_second_stalls got=%0d want=33", st2); end
      n_vec++; if (sar1 !== 1'b0) begin n_err++; $display("FAIL b2b_stall_at_ready got=%b want=0", sar1); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_reset_mid();
      test_signed();
      test_divzero();
      test_annul();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
